alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Round-robin controller that shares one 4-bit add/sub unit between two requesters.
//  Arbitrates the requesters and drives the unit's enable, select and operand inputs.
//  Captures the unit's result into a register and returns it with a one-cycle done pulse.
//  Sits between two client FSMs and the add/sub unit. The unit outputs 4'b1111 when disabled.
// PARAMETERS
//  WIDTH   4  operand/result width, matching the add/sub unit
//  SETTLE  1  cycles alu_enable is held before capture (>=1), counter width $clog2(SETTLE+1)
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  rst_n       in   1      synchronous reset, active low
//  req0/req1   in   1      channel request; level, held until gnt of that channel
//  op0/op1     in   1      channel operation: 0 = a+b, 1 = a-b
//  a0/a1       in   WIDTH  channel operand a, sampled in the grant cycle
//  b0/b1       in   WIDTH  channel operand b, sampled in the grant cycle
//  gnt0/gnt1   out  1      one-cycle pulse: channel accepted, operands latched
//  done0/done1 out  1      one-cycle pulse: result valid for that channel
//  result      out  WIDTH  last captured result; holds until next capture
//  busy        out  1      1 whenever state != IDLE
//  alu_enable  out  1      to unit enable
//  alu_select  out  1      to unit select
//  alu_a       out  WIDTH  to unit input_a
//  alu_b       out  WIDTH  to unit input_b
//  alu_result  in   WIDTH  from unit output
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; every output 0; settle count 0; RR pointer -> ch0.
//  - States:
//    IDLE: any req -> ISSUE. Latch op/a/b of winner into alu_select/alu_a/alu_b; pulse gnt.
//    ISSUE: alu_enable=1. Count SETTLE cycles, then -> DONE; result<=alu_result at that edge.
//    DONE: alu_enable=0; done of owner=1 for this cycle only; -> IDLE.
//  - Timing: req seen at edge N -> gnt/busy/alu_enable high in cycle N+1.
//    result and done valid in cycle N+1+SETTLE; IDLE again at N+2+SETTLE.
//  - Arbitration: both req in IDLE -> grant the channel not granted last.
//    Pointer updates on each grant. After reset ch0 wins a tie.
//    A single request is always granted, regardless of the pointer.
//  - Requests are not sampled outside IDLE; no queueing. A req still high after done = new request.
//  - alu_a/alu_b/alu_select hold their latched values until the next grant (stable in ISSUE).
//  - Arithmetic done by the unit; result is modulo 2^WIDTH (3-5 -> 4'hE, 9+8 -> 4'h1).
//  - Only the owning channel's gnt/done pulse; gnt0&gnt1 and done0&done1 are never 1.
//  - Reset mid-transaction aborts it. No done is issued and the unit is disabled next cycle.
// CONFIGURATION
//  ALU_SHARE_FLAG_EN defined: extra output flag (1 bit), registered with result.
//    add: carry out of a+b. sub: borrow (a<b). Computed internally from latched operands.
//    Reset 0; holds until next capture.
//  Undefined: no flag port; carry/borrow is not computed.
// TESTING
//  1 reset: rst_n=0 two cycles -> all outputs 0, busy=0; ch0 wins the first tie.
//  2 req0, op0=0, a0=3, b0=5 (SETTLE=1) -> gnt0 at N+1; result=8, done0 at N+2; IDLE at N+3.
//  3 req1, op1=1, a1=3, b1=5 -> result=4'hE, done1 only; with flag_en flag=1 (borrow).
//  4 req0 and req1 held high continuously -> grants alternate 0,1,0,1.
//    Each done matches its own operands; no lost or double grants.
//  5 rst_n=0 during ISSUE -> next cycle alu_enable=0, busy=0; no done pulse; pointer at ch0.
//  6 req0, a0=9, b0=8, op0=0 -> result=4'h1; flag=1 when flag_en; alu_a/b stable through ISSUE.

Source files
------------

// File: rtl/alu_share_if.sv
// Client-side bus of the shared add/sub controller.
// master = client pair, slave = controller.
interface alu_share_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic             req1;
   logic             op0;
   logic             op1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] b1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] result;
   logic             busy;

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1,
      input  gnt0, gnt1, done0, done1, result, busy
   );

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1,
      output gnt0, gnt1, done0, done1, result, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one add/sub unit between two channels.
// Optional ALU_SHARE_FLAG_EN adds a registered carry/borrow flag_o.
module alu_share_ctrl #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_share_if.slave       bus,
   output logic             alu_enable_o,
   output logic             alu_select_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_result_i
`ifdef ALU_SHARE_FLAG_EN
   ,
   output logic             flag_o
`endif
);

   localparam int CW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             prio_q;
   logic             owner_q;
   logic             sel_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             win;
   logic             grant;
   logic             capture;

`ifdef ALU_SHARE_FLAG_EN
   logic             flag_q;
   logic             flag_d;
   logic [WIDTH:0]   sum_w;

   // carry of a+b or borrow of a-b from the latched operands
   always_comb begin
      sum_w  = {1'b0, a_q} + {1'b0, b_q};
      flag_d = sel_q ? (a_q < b_q) : sum_w[WIDTH];
   end

   assign flag_o = flag_q;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state, arbitration and settle counting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;
      capture = 1'b0;
      if (bus.req0 && bus.req1) win = prio_q;
      else                      win = bus.req1;
      unique case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d = ISSUE;
               cnt_d   = '0;
               grant   = 1'b1;
            end
         end
         ISSUE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = DONE;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand latch on grant, result capture at end of settle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         sel_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
`ifdef ALU_SHARE_FLAG_EN
         flag_q  <= 1'b0;
`endif
      end else begin
         if (grant) begin
            owner_q <= win;
            prio_q  <= ~win;
            sel_q   <= win ? bus.op1 : bus.op0;
            a_q     <= win ? bus.a1 : bus.a0;
            b_q     <= win ? bus.b1 : bus.b0;
         end
         if (capture) begin
            res_q  <= alu_result_i;
`ifdef ALU_SHARE_FLAG_EN
            flag_q <= flag_d;
`endif
         end
      end
   end

   // outputs decoded from state and owner
   always_comb begin
      alu_enable_o = (state_q == ISSUE);
      alu_select_o = sel_q;
      alu_a_o      = a_q;
      alu_b_o      = b_q;
      bus.busy     = (state_q != IDLE);
      bus.result   = res_q;
      bus.gnt0     = (state_q == ISSUE) && (cnt_q == '0) && !owner_q;
      bus.gnt1     = (state_q == ISSUE) && (cnt_q == '0) && owner_q;
      bus.done0    = (state_q == DONE) && !owner_q;
      bus.done1    = (state_q == DONE) && owner_q;
   end

endmodule
